// File: rtl/wishbone_master_bus_if.sv
// CPU-side Wishbone classic master: turns one SRAM-style pipeline request into one
// registered Wishbone cycle, stalls the pipeline until ack, and aborts on flush or ack timeout.
module wishbone_master_bus_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SEL_WIDTH   = 4,
    parameter int unsigned STALL_WIDTH = 6,
    parameter int unsigned ACK_TIMEOUT = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_ce_i,
    input  logic                   cpu_we_i,
    input  logic [ADDR_WIDTH-1:0]  cpu_addr_i,
    input  logic [DATA_WIDTH-1:0]  cpu_data_i,
    input  logic [SEL_WIDTH-1:0]   cpu_sel_i,
    output logic [DATA_WIDTH-1:0]  cpu_data_o,
    input  logic [STALL_WIDTH-1:0] stall_i,
    input  logic                   flush_i,
    output logic                   stallreq_o,
    output logic                   bus_err_o,
    output logic                   wishbone_cyc_o,
    output logic                   wishbone_stb_o,
    output logic                   wishbone_we_o,
    output logic [ADDR_WIDTH-1:0]  wishbone_addr_o,
    output logic [DATA_WIDTH-1:0]  wishbone_data_o,
    output logic [SEL_WIDTH-1:0]   wishbone_sel_o,
    input  logic [DATA_WIDTH-1:0]  wishbone_data_i,
    input  logic                   wishbone_ack_i
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam bit TIMEOUT_EN = (ACK_TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUSY       = 2'd1,
        WAIT_STALL = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    cyc_q, cyc_d;
    logic                    stb_q, stb_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   rd_buf_q, rd_buf_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    bus_err_q, bus_err_d;

    // Next-state, bus register updates and combinational pipeline handshake
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        sel_d      = sel_q;
        rd_buf_d   = rd_buf_q;
        cnt_d      = cnt_q;
        bus_err_d  = 1'b0;
        stallreq_o = 1'b0;
        cpu_data_o = '0;

        case (state_q)
            IDLE: begin
                stallreq_o = cpu_ce_i & ~flush_i;
                if (cpu_ce_i && !flush_i) begin
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = cpu_we_i;
                    addr_d  = cpu_addr_i;
                    data_d  = cpu_data_i;
                    sel_d   = cpu_sel_i;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    we_d     = 1'b0;
                    sel_d    = '0;
                    rd_buf_d = '0;
                    state_d  = IDLE;
                end else if (wishbone_ack_i) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    sel_d = '0;
                    if (!we_q) begin
                        rd_buf_d   = wishbone_data_i;
                        cpu_data_o = wishbone_data_i;
                    end
                    state_d = (stall_i != '0) ? WAIT_STALL : IDLE;
                end else begin
                    stallreq_o = 1'b1;
                    // Last permitted wait cycle without ack: give up on the slave
                    if (TIMEOUT_EN && cnt_q == CNT_LAST) begin
                        cyc_d     = 1'b0;
                        stb_d     = 1'b0;
                        we_d      = 1'b0;
                        sel_d     = '0;
                        rd_buf_d  = '0;
                        bus_err_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WAIT_STALL: begin
                cpu_data_o = rd_buf_q;
                if (stall_i == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            sel_q     <= '0;
            rd_buf_q  <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            sel_q     <= sel_d;
            rd_buf_q  <= rd_buf_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign wishbone_cyc_o  = cyc_q;
    assign wishbone_stb_o  = stb_q;
    assign wishbone_we_o   = we_q;
    assign wishbone_addr_o = addr_q;
    assign wishbone_data_o = data_q;
    assign wishbone_sel_o  = sel_q;
    assign bus_err_o       = bus_err_q;

endmodule

// File: tb/tb_wishbone_master_bus_if.sv
// Bench for wishbone_master_bus_if: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_wishbone_master_bus_if;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce, we, flush, ack;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  sel;
    logic [5:0]  stall;
    logic [31:0] cpu_data;
    logic        stallreq, bus_err;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_addr, wb_data;
    logic [3:0]  wb_sel;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wishbone_master_bus_if #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4), .STALL_WIDTH(6), .ACK_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_ce_i(ce), .cpu_we_i(we), .cpu_addr_i(addr), .cpu_data_i(wdata), .cpu_sel_i(sel),
        .cpu_data_o(cpu_data), .stall_i(stall), .flush_i(flush),
        .stallreq_o(stallreq), .bus_err_o(bus_err),
        .wishbone_cyc_o(wb_cyc), .wishbone_stb_o(wb_stb), .wishbone_we_o(wb_we),
        .wishbone_addr_o(wb_addr), .wishbone_data_o(wb_data), .wishbone_sel_o(wb_sel),
        .wishbone_data_i(rdata), .wishbone_ack_i(ack)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: one outstanding bus transaction, plus a held read result
    bit          m_valid = 1'b0;
    bit          m_cyc, m_we, m_hold, m_err;
    logic [31:0] m_addr, m_data, m_buf;
    logic [3:0]  m_sel;
    int          m_waits;

    task automatic end_txn();
        m_cyc = 1'b0;
        m_we  = 1'b0;
        m_sel = '0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_cyc = 0; m_we = 0; m_hold = 0; m_err = 0;
            m_addr = '0; m_data = '0; m_buf = '0; m_sel = '0; m_waits = 0;
        end else if (m_valid) begin
            m_err = 1'b0;
            if (m_cyc) begin
                if (flush) begin
                    end_txn();
                    m_buf = '0;
                end else if (ack) begin
                    if (!m_we) m_buf = rdata;
                    m_hold = (stall != 0);
                    end_txn();
                end else begin
                    m_waits++;
                    if (TO != 0 && m_waits == int'(TO)) begin
                        end_txn();
                        m_buf = '0;
                        m_err = 1'b1;
                    end
                end
            end else if (m_hold) begin
                if (stall == 0) m_hold = 1'b0;
            end else if (ce && !flush) begin
                m_cyc = 1'b1; m_we = we; m_addr = addr; m_data = wdata; m_sel = sel; m_waits = 0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            logic        e_stallreq;
            logic [31:0] e_data;
            if (m_cyc) begin
                e_stallreq = !flush && !ack;
                e_data     = (!flush && ack && !m_we) ? rdata : 32'h0;
            end else if (m_hold) begin
                e_stallreq = 1'b0;
                e_data     = m_buf;
            end else begin
                e_stallreq = ce && !flush;
                e_data     = 32'h0;
            end
            chk("m_cyc",      32'(wb_cyc),   32'(m_cyc));
            chk("m_stb",      32'(wb_stb),   32'(m_cyc));
            chk("m_we",       32'(wb_we),    32'(m_we));
            chk("m_addr",     wb_addr,       m_addr);
            chk("m_wdata",    wb_data,       m_data);
            chk("m_sel",      32'(wb_sel),   32'(m_sel));
            chk("m_bus_err",  32'(bus_err),  32'(m_err));
            chk("m_stallreq", 32'(stallreq), 32'(e_stallreq));
            chk("m_cpu_data", cpu_data,      e_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; ce = 0; we = 0; flush = 0; ack = 0;
        addr = '0; wdata = '0; rdata = '0; sel = '0; stall = '0;
        step(); step();
        rst = 0;
        @(negedge clk);
        chk("rst_cyc", 32'(wb_cyc), 0); chk("rst_err", 32'(bus_err), 0);
        chk("rst_addr", wb_addr, 0);    chk("rst_stallreq", 32'(stallreq), 0);
        step();

        // Read acked in first BUSY cycle
        ce = 1; we = 0; addr = 32'h100; sel = 4'hF;
        @(negedge clk); chk("t1_req_stallreq", 32'(stallreq), 1);
        step();
        ack = 1; rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_busy_cyc", 32'(wb_cyc), 1); chk("t1_busy_addr", wb_addr, 32'h100);
        chk("t1_ack_data", cpu_data, 32'hDEADBEEF); chk("t1_ack_stallreq", 32'(stallreq), 0);
        step();
        ce = 0; ack = 0;
        @(negedge clk); chk("t1_cyc_clr", 32'(wb_cyc), 0);
        step();

        // Write acked after 3 wait cycles (ack on the last permitted cycle)
        ce = 1; we = 1; addr = 32'h200; wdata = 32'h12345678; sel = 4'h3;
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_wait_stallreq", 32'(stallreq), 1); chk("t2_wb_we", 32'(wb_we), 1);
            chk("t2_wb_data", wb_data, 32'h12345678);  chk("t2_wb_sel", 32'(wb_sel), 32'h3);
            step();
        end
        ack = 1;
        @(negedge clk);
        chk("t2_ack_stallreq", 32'(stallreq), 0); chk("t2_ack_cyc", 32'(wb_cyc), 1);
        chk("t2_ack_data", cpu_data, 0);
        step();
        ce = 0; ack = 0;
        @(negedge clk); chk("t2_cyc_clr", 32'(wb_cyc), 0); chk("t2_err", 32'(bus_err), 0);
        step();

        // Read ack while pipeline stalled
        ce = 1; we = 0; addr = 32'h300; sel = 4'hF;
        step();
        ack = 1; rdata = 32'hCAFEF00D; stall = 6'b000011;
        @(negedge clk); chk("t3_ack_data", cpu_data, 32'hCAFEF00D);
        step();
        ce = 0; ack = 0; rdata = 32'h0;
        @(negedge clk); chk("t3_hold1", cpu_data, 32'hCAFEF00D); chk("t3_hold1_stallreq", 32'(stallreq), 0);
        step();
        stall = 0;
        @(negedge clk); chk("t3_hold2", cpu_data, 32'hCAFEF00D);
        step();
        @(negedge clk); chk("t3_idle_data", cpu_data, 0);
        step();

        // Flush in the second BUSY cycle, then a late ack
        ce = 1; we = 0; addr = 32'h400; sel = 4'hF;
        step();
        @(negedge clk); chk("t4_busy1_stallreq", 32'(stallreq), 1);
        step();
        flush = 1;
        @(negedge clk); chk("t4_flush_stallreq", 32'(stallreq), 0);
        step();
        flush = 0; ce = 0; ack = 1; rdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("t4_cyc_clr", 32'(wb_cyc), 0); chk("t4_late_ack_data", cpu_data, 0);
        chk("t4_err", 32'(bus_err), 0);
        step();
        ack = 0;
        @(negedge clk); chk("t4_err2", 32'(bus_err), 0); chk("t4_stb", 32'(wb_stb), 0);
        step();

        // Ack timeout
        ce = 1; we = 0; addr = 32'h500; sel = 4'hF;
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_cyc_held", 32'(wb_cyc), 1); chk("t5_stallreq", 32'(stallreq), 1);
            step();
        end
        ce = 0;
        @(negedge clk);
        chk("t5_cyc_clr", 32'(wb_cyc), 0); chk("t5_err_pulse", 32'(bus_err), 1);
        chk("t5_released", 32'(stallreq), 0);
        step();
        @(negedge clk); chk("t5_err_end", 32'(bus_err), 0);
        step();

        // Reset during BUSY, then a normal read
        ce = 1; we = 1; addr = 32'h600; wdata = 32'hA5A5A5A5; sel = 4'hF;
        step();
        rst = 1; ce = 0;
        @(negedge clk); chk("t6_busy_cyc", 32'(wb_cyc), 1);
        step();
        rst = 0;
        @(negedge clk);
        chk("t6_cyc", 32'(wb_cyc), 0); chk("t6_addr", wb_addr, 0);
        chk("t6_data", wb_data, 0);    chk("t6_sel", 32'(wb_sel), 0);
        step();
        ce = 1; we = 0; addr = 32'h700; sel = 4'hF;
        step();
        ack = 1; rdata = 32'h55AA55AA;
        @(negedge clk); chk("t6_read_data", cpu_data, 32'h55AA55AA); chk("t6_read_addr", wb_addr, 32'h700);
        step();
        ce = 0; ack = 0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
